// File: rtl/fp_lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire membrane engine.
// Also holds the leading-zero counter used by the float adder's normaliser.
package fp_lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAK = 2'd1,
        CMP  = 2'd2,
        FIRE = 2'd3
    } lif_state_t;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP_DECAY    = 32'h3DCC_CCCD;
    localparam int          FP_SIGN_BIT = 31;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Returns 48 for an all-zero input so the shifted value collapses to zero.
    function automatic logic [5:0] clz48(input logic [47:0] x);
        logic [5:0] n;
        logic       found;
        n     = 6'd48;
        found = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = 6'(47 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_lif_membrane_addsub.sv
// Combinational IEEE-754 single-precision add/subtract with truncation (no rounding).
// Inf/NaN operands raise Exception and force a zero result; tiny results flush to zero.
module Addition_Subtraction
    import fp_lif_pkg::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);

    logic        b_sign_s;
    logic        swap_s;
    logic [31:0] big_s;
    logic [31:0] small_s;
    logic [7:0]  shift_s;
    logic [47:0] man_big_s;
    logic [47:0] man_small_s;
    logic [47:0] man_al_s;
    logic [48:0] sum_s;
    logic [5:0]  lz_s;
    logic [9:0]  exp_res_s;
    logic [22:0] frac_s;

    // Align on a 48-bit datapath so the subtraction sees every shifted-out bit before truncation.
    always_comb begin
        Exception   = (&a_operand[30:23]) | (&b_operand[30:23]);
        b_sign_s    = b_operand[31] ^ AddBar_Sub;
        swap_s      = (b_operand[30:0] > a_operand[30:0]);
        big_s       = swap_s ? {b_sign_s, b_operand[30:0]} : a_operand;
        small_s     = swap_s ? a_operand : {b_sign_s, b_operand[30:0]};
        man_big_s   = {(|big_s[30:23]), big_s[22:0], 24'd0};
        man_small_s = {(|small_s[30:23]), small_s[22:0], 24'd0};
        shift_s     = big_s[30:23] - small_s[30:23];
        man_al_s    = (shift_s > 8'd47) ? 48'd0 : (man_small_s >> shift_s);
        if (big_s[31] == small_s[31]) begin
            sum_s = {1'b0, man_big_s} + {1'b0, man_al_s};
        end else begin
            sum_s = {1'b0, man_big_s} - {1'b0, man_al_s};
        end
        lz_s      = clz48(sum_s[47:0]);
        frac_s    = 23'((sum_s[47:0] << lz_s) >> 24);
        exp_res_s = {2'b00, big_s[30:23]} - {4'd0, lz_s};

        if (Exception) begin
            result = FP_ZERO;
        end else if (sum_s[48]) begin
            if (big_s[30:23] == 8'hFE) begin
                result = {big_s[31], 8'hFF, 23'd0};
            end else begin
                result = {big_s[31], big_s[30:23] + 8'd1, sum_s[47:25]};
            end
        end else if (sum_s[47:0] == 48'd0) begin
            result = FP_ZERO;
        end else if (exp_res_s[9] || (exp_res_s == 10'd0)) begin
            result = FP_ZERO;
        end else begin
            result = {big_s[31], exp_res_s[7:0], frac_s};
        end
    end

endmodule

// File: rtl/fp_lif_membrane.sv
// Membrane-potential engine for one LIF neuron: accumulates weights, then per timestep
// leaks, compares against threshold and fires, all through one shared float adder.
module fp_lif_membrane
    import fp_lif_pkg::*;
#(
    parameter logic [31:0] THRESHOLD = FP_ONE,
    parameter logic [31:0] DECAY     = FP_DECAY,
    parameter logic [31:0] V_RESET   = FP_ZERO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_weight,
    input  logic        step_start,
    output logic        step_done,
    output logic        spike_out,
    output logic [31:0] v_mem,
    input  logic        err_clr,
    output logic        err_sticky
);

    lif_state_t  state_r;
    lif_state_t  state_s;
    logic [31:0] v_mem_r;
    logic [31:0] v_next_s;
    logic [31:0] add_b_s;
    logic        add_op_s;
    logic        op_active_s;
    logic        fire_s;
    logic [31:0] add_res_s;
    logic        add_exc_s;
    logic        fire_q_r;
    logic        step_done_r;
    logic        in_ready_r;
    logic        err_r;

    Addition_Subtraction u_addsub (
        .a_operand  (v_mem_r),
        .b_operand  (add_b_s),
        .AddBar_Sub (add_op_s),
        .Exception  (add_exc_s),
        .result     (add_res_s)
    );

    // Adder operand mux, next potential and next state, all selected by the current state.
    always_comb begin
        state_s     = state_r;
        v_next_s    = v_mem_r;
        add_b_s     = FP_ZERO;
        add_op_s    = OP_ADD;
        op_active_s = 1'b0;
        fire_s      = 1'b0;
        case (state_r)
            IDLE: begin
                add_b_s     = in_weight;
                op_active_s = in_valid;
                if (in_valid && !add_exc_s) begin
                    v_next_s = add_res_s;
                end else begin
                    v_next_s = v_mem_r;
                end
                if (step_start) begin
                    state_s = LEAK;
                end else begin
                    state_s = IDLE;
                end
            end
            LEAK: begin
                add_b_s     = DECAY;
                add_op_s    = OP_SUB;
                op_active_s = 1'b1;
                if (add_exc_s) begin
                    v_next_s = v_mem_r;
                end else if (add_res_s[FP_SIGN_BIT]) begin
                    v_next_s = V_RESET;
                end else begin
                    v_next_s = add_res_s;
                end
                state_s = CMP;
            end
            CMP: begin
                add_b_s     = THRESHOLD;
                add_op_s    = OP_SUB;
                op_active_s = 1'b1;
                fire_s      = !add_exc_s && !add_res_s[FP_SIGN_BIT];
                state_s     = FIRE;
            end
            FIRE: begin
                if (fire_q_r) begin
                    v_next_s = V_RESET;
                end else begin
                    v_next_s = v_mem_r;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, potential and registered handshake/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            v_mem_r     <= V_RESET;
            fire_q_r    <= 1'b0;
            step_done_r <= 1'b0;
            in_ready_r  <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            v_mem_r     <= v_next_s;
            fire_q_r    <= fire_s;
            step_done_r <= (state_r == CMP);
            in_ready_r  <= (state_s == IDLE);
            if (op_active_s && add_exc_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign step_done  = step_done_r;
    assign spike_out  = fire_q_r;
    assign v_mem      = v_mem_r;
    assign err_sticky = err_r;

endmodule
